// File: rtl/ddr3_rx_align_pkg.sv
// Shared types and constants for the DDR3 receive-lane alignment controller.
package ddr3_rx_align_pkg;

   localparam int unsigned TAP_W = 8;

   // Slip counter width for a given slip budget, never narrower than one bit.
   function automatic int unsigned slip_cnt_w(input int unsigned max_slips);
      return (max_slips > 1) ? $clog2(max_slips) : 1;
   endfunction

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_STEP,
      ST_SLIP,
      ST_CENTER,
      ST_DONE,
      ST_ERROR
   } align_state_e;

endpackage

// File: rtl/ddr3_rx_pattern_checker.sv
// Counts consecutive deserialized words matching the training pattern.
// start_i is held high for the whole sampling window; while it is low the
// run counter is kept cleared. done_o strobes on the first mismatch (fail)
// or on the SAMPLE_WORDS-th consecutive match (pass), with pass_o alongside.
module ddr3_rx_pattern_checker #(
   parameter int unsigned SAMPLE_WORDS = 8
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic [7:0] rx_data_i,
   input  logic [7:0] pattern_i,
   output logic       done_o,
   output logic       pass_o
);

   localparam int unsigned CW = (SAMPLE_WORDS > 1) ? $clog2(SAMPLE_WORDS) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          match;

   // Word compare, end-of-window detection and run counter next state.
   always_comb begin
      match  = (rx_data_i == pattern_i);
      pass_o = match;
      done_o = start_i && (!match || (cnt_q == CW'(SAMPLE_WORDS - 1)));
      if (!start_i || done_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Run counter register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ddr3_rx_iod_align_ctrl.sv
// Read-path training controller for one DDR3 input lane: sweeps the IOD
// delay line for the passing eye, centres the tap in it, and bit-slips until
// the deserialized word lines up with the training pattern.
module ddr3_rx_iod_align_ctrl
   import ddr3_rx_align_pkg::*;
#(
   parameter int unsigned MAX_TAP       = 127,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned SAMPLE_WORDS  = 8,
   parameter int unsigned MIN_WINDOW    = 4,
   parameter int unsigned MAX_SLIPS     = 8
) (
   input  logic       FAB_CLK,
   input  logic       ARST_N,
   input  logic       START,
   input  logic [7:0] PATTERN,
   input  logic [7:0] RX_DATA_0,
   input  logic       DELAY_LINE_OUT_OF_RANGE_0,
   output logic       DELAY_LINE_LOAD_0,
   output logic       DELAY_LINE_MOVE_0,
   output logic       DELAY_LINE_DIRECTION_0,
   output logic       RX_BIT_SLIP_0,
   output logic       TRAIN_DONE,
   output logic       TRAIN_ERROR,
   output logic [7:0] TAP_OUT,
   output logic [7:0] WINDOW_WIDTH
);

   localparam int unsigned SLW  = slip_cnt_w(MAX_SLIPS);
   localparam int unsigned SETW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   align_state_e     state_q, state_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [TAP_W-1:0] first_q, first_d;
   logic [TAP_W-1:0] last_q, last_d;
   logic [TAP_W-1:0] target_q, target_d;
   logic [TAP_W-1:0] ww_q, ww_d;
   logic [SLW-1:0]   slip_q, slip_d;
   logic [SETW-1:0]  settle_q, settle_d;
   logic             first_vld_q, first_vld_d;
   logic             pass_q, pass_d;
   logic             idle_q, idle_d;

   logic             chk_start;
   logic             chk_done;
   logic             chk_pass;
   logic             end_sweep;
   logic             accept;
   logic [TAP_W-1:0] first_eff;
   logic [TAP_W-1:0] diff;

   assign chk_start = (state_q == ST_SAMPLE);

   ddr3_rx_pattern_checker #(
      .SAMPLE_WORDS (SAMPLE_WORDS)
   ) u_checker (
      .clk_i     (FAB_CLK),
      .rst_n_i   (ARST_N),
      .start_i   (chk_start),
      .rx_data_i (RX_DATA_0),
      .pattern_i (PATTERN),
      .done_o    (chk_done),
      .pass_o    (chk_pass)
   );

   // Next-state, datapath updates and pulse outputs of the training FSM.
   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      first_d     = first_q;
      last_d      = last_q;
      target_d    = target_q;
      ww_d        = ww_q;
      slip_d      = slip_q;
      settle_d    = settle_q;
      first_vld_d = first_vld_q;
      pass_d      = pass_q;
      idle_d      = idle_q;

      DELAY_LINE_LOAD_0      = 1'b0;
      DELAY_LINE_MOVE_0      = 1'b0;
      DELAY_LINE_DIRECTION_0 = 1'b0;
      RX_BIT_SLIP_0          = 1'b0;

      end_sweep = (tap_q == TAP_W'(MAX_TAP)) || DELAY_LINE_OUT_OF_RANGE_0;
      // A pass on the very tap that ends the sweep opens and closes the eye
      // in the same evaluation, so the window start is taken from tap_q then.
      first_eff = first_vld_q ? first_q : tap_q;
      accept    = 1'b0;
      diff      = '0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (START) begin
               slip_d      = '0;
               first_vld_d = 1'b0;
               state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            DELAY_LINE_LOAD_0 = 1'b1;
            tap_d             = '0;
            settle_d          = '0;
            state_d           = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == SETW'(SETTLE_CYCLES - 1)) begin
               settle_d = '0;
               state_d  = ST_SAMPLE;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (chk_done) begin
               pass_d  = chk_pass;
               state_d = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (pass_q && !first_vld_q) begin
               first_d     = tap_q;
               first_vld_d = 1'b1;
            end
            if (!pass_q && first_vld_q) begin
               last_d = tap_q - 1'b1;
               accept = 1'b1;
            end else if (pass_q && end_sweep) begin
               last_d = tap_q;
               accept = 1'b1;
            end else if (end_sweep) begin
               state_d = ST_SLIP;
            end else begin
               state_d = ST_STEP;
            end
            if (accept) begin
               diff = last_d - first_eff;
               if (({1'b0, diff} + 1'b1) < (TAP_W + 1)'(MIN_WINDOW)) begin
                  state_d = ST_SLIP;
               end else begin
                  ww_d     = diff + 1'b1;
                  // first + floor((last-first)/2) == floor((first+last)/2)
                  // without needing a carry bit.
                  target_d = first_eff + (diff >> 1);
                  idle_d   = 1'b0;
                  state_d  = ST_CENTER;
               end
            end
         end
         ST_STEP: begin
            DELAY_LINE_MOVE_0      = 1'b1;
            DELAY_LINE_DIRECTION_0 = 1'b1;
            if (tap_q != TAP_W'(MAX_TAP)) begin
               tap_d = tap_q + 1'b1;
            end
            settle_d = '0;
            state_d  = ST_SETTLE;
         end
         ST_SLIP: begin
            if (slip_q == SLW'(MAX_SLIPS - 1)) begin
               state_d = ST_ERROR;
            end else begin
               RX_BIT_SLIP_0 = 1'b1;
               slip_d        = slip_q + 1'b1;
               first_vld_d   = 1'b0;
               state_d       = ST_LOAD;
            end
         end
         ST_CENTER: begin
            // Each decrement is a MOVE cycle followed by an idle cycle; the
            // idle slot itself hands over to DONE once the target is reached.
            if (idle_q) begin
               idle_d = 1'b0;
               if (tap_q == target_q) begin
                  state_d = ST_DONE;
               end
            end else if (tap_q > target_q) begin
               DELAY_LINE_MOVE_0 = 1'b1;
               tap_d             = tap_q - 1'b1;
               idle_d            = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         state_q     <= ST_IDLE;
         tap_q       <= '0;
         first_q     <= '0;
         last_q      <= '0;
         target_q    <= '0;
         ww_q        <= '0;
         slip_q      <= '0;
         settle_q    <= '0;
         first_vld_q <= 1'b0;
         pass_q      <= 1'b0;
         idle_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         first_q     <= first_d;
         last_q      <= last_d;
         target_q    <= target_d;
         ww_q        <= ww_d;
         slip_q      <= slip_d;
         settle_q    <= settle_d;
         first_vld_q <= first_vld_d;
         pass_q      <= pass_d;
         idle_q      <= idle_d;
      end
   end

   assign TRAIN_DONE   = (state_q == ST_DONE);
   assign TRAIN_ERROR  = (state_q == ST_ERROR);
   assign TAP_OUT      = tap_q;
   assign WINDOW_WIDTH = ww_q;

endmodule
